// File: rtl/apb_arbiter_rr.sv
// rtl/apb_arbiter_rr.sv - round-robin arbiter sharing one downstream APB master port
// Requesters are served one at a time through a registered IDLE/SETUP/ACCESS/RESP sequence.
module apb_arbiter_rr #(
  parameter int BUS_WIDTH    = 16,
  parameter int DATA_WIDTH   = 16,
  parameter int MASTER_PORTS = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [MASTER_PORTS*BUS_WIDTH-1:0]    S_PADDR,
  input  logic [MASTER_PORTS-1:0]              S_PWRITE,
  input  logic [MASTER_PORTS-1:0]              S_PSELx,
  input  logic [MASTER_PORTS-1:0]              S_PENABLE,
  input  logic [MASTER_PORTS*DATA_WIDTH-1:0]   S_PWDATA,
  output logic [MASTER_PORTS*DATA_WIDTH-1:0]   S_PRDATA,
  output logic [MASTER_PORTS-1:0]              S_PREADY,
  output logic [MASTER_PORTS-1:0]              S_PSLVERR,
  output logic [BUS_WIDTH-1:0]                 M_PADDR,
  output logic                                 M_PWRITE,
  output logic                                 M_PSELx,
  output logic                                 M_PENABLE,
  output logic [DATA_WIDTH-1:0]                M_PWDATA,
  input  logic [DATA_WIDTH-1:0]                M_PRDATA,
  input  logic                                 M_PREADY,
  output logic [$clog2(MASTER_PORTS)-1:0]      grant,
  output logic                                 busy
);

  localparam int IDX_W = $clog2(MASTER_PORTS);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [IDX_W-1:0] LAST_INIT = IDX_W'(MASTER_PORTS - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] RESP   = 2'd3;

  logic [1:0]              state;
  logic [IDX_W-1:0]        last;
  logic [CNT_W-1:0]        count;
  logic                    pick_valid;
  logic [IDX_W-1:0]        pick_idx;
  logic [IDX_W-1:0]        rr_idx;
  logic [MASTER_PORTS-1:0] grant_onehot;
  logic                    timed_out;

  // Sequencing is regenerated locally, so the requesters' enables carry no information.
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  // Scan from farthest to nearest so the requester closest after last wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    rr_idx     = '0;
    for (int k = MASTER_PORTS; k >= 1; k--) begin
      rr_idx = IDX_W'((int'(last) + k) % MASTER_PORTS);
      if (S_PSELx[rr_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_idx;
      end
    end
  end

  always_comb begin
    grant_onehot        = '0;
    grant_onehot[grant] = 1'b1;
  end

  assign timed_out = (TIMEOUT != 0) && (count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= LAST_INIT;
      count     <= '0;
      grant     <= '0;
      busy      <= 1'b0;
      M_PADDR   <= '0;
      M_PWRITE  <= 1'b0;
      M_PWDATA  <= '0;
      M_PSELx   <= 1'b0;
      M_PENABLE <= 1'b0;
      S_PRDATA  <= '0;
      S_PREADY  <= '0;
      S_PSLVERR <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant     <= pick_idx;
            M_PADDR   <= S_PADDR[int'(pick_idx)*BUS_WIDTH +: BUS_WIDTH];
            M_PWRITE  <= S_PWRITE[pick_idx];
            M_PWDATA  <= S_PWDATA[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            M_PSELx   <= 1'b1;
            M_PENABLE <= 1'b0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          M_PENABLE <= 1'b1;
          count     <= '0;
          state     <= ACCESS;
        end
        ACCESS: begin
          if (M_PREADY) begin
            M_PSELx   <= 1'b0;
            M_PENABLE <= 1'b0;
            S_PRDATA  <= '0;
            S_PRDATA[int'(grant)*DATA_WIDTH +: DATA_WIDTH] <= M_PRDATA;
            S_PSLVERR <= '0;
            S_PREADY  <= grant_onehot;
            state     <= RESP;
          end else if (timed_out) begin
            // Abandon the slave: return zero data with an error flag.
            M_PSELx   <= 1'b0;
            M_PENABLE <= 1'b0;
            S_PRDATA  <= '0;
            S_PSLVERR <= grant_onehot;
            S_PREADY  <= grant_onehot;
            state     <= RESP;
          end else if (count != CNT_MAX) begin
            count <= count + 1'b1;
          end
        end
        RESP: begin
          S_PREADY  <= '0;
          S_PSLVERR <= '0;
          last      <= grant;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter_rr.sv
// tb/tb_apb_arbiter_rr.sv - directed scoreboard bench for apb_arbiter_rr
module tb_apb_arbiter_rr;

  localparam int AW = 16;
  localparam int DW = 16;
  localparam int N  = 4;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*AW-1:0] s_paddr;
  logic [N-1:0]    s_pwrite;
  logic [N-1:0]    s_psel;
  logic [N-1:0]    s_penable;
  logic [N*DW-1:0] s_pwdata;
  logic [N*DW-1:0] s_prdata;
  logic [N-1:0]    s_pready;
  logic [N-1:0]    s_pslverr;
  logic [AW-1:0]   m_paddr;
  logic            m_pwrite;
  logic            m_psel;
  logic            m_penable;
  logic [DW-1:0]   m_pwdata;
  logic [DW-1:0]   m_prdata;
  logic            m_pready;
  logic [1:0]      grant;
  logic            busy;

  apb_arbiter_rr #(.BUS_WIDTH(AW), .DATA_WIDTH(DW), .MASTER_PORTS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(s_paddr), .S_PWRITE(s_pwrite), .S_PSELx(s_psel), .S_PENABLE(s_penable),
    .S_PWDATA(s_pwdata), .S_PRDATA(s_prdata), .S_PREADY(s_pready), .S_PSLVERR(s_pslverr),
    .M_PADDR(m_paddr), .M_PWRITE(m_pwrite), .M_PSELx(m_psel), .M_PENABLE(m_penable),
    .M_PWDATA(m_pwdata), .M_PRDATA(m_prdata), .M_PREADY(m_pready),
    .grant(grant), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [DW-1:0] rdata;
    logic          err;
  } resp_t;

  resp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int resp_count = 0;

  // Slave model: ready after slave_wait wait states, data derived from the address.
  logic          slave_never;
  int            slave_wait;
  logic [DW-1:0] slave_key;
  int            acc_cnt = 0;

  always @(negedge clk) begin
    if (m_psel && m_penable) acc_cnt = acc_cnt + 1;
    else acc_cnt = 0;
  end

  assign m_pready = m_psel && m_penable && !slave_never && (acc_cnt > slave_wait);
  assign m_prdata = m_paddr ^ slave_key;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    resp_t e;
    logic [N*DW-1:0] exp_rd;
    if (!reset && s_pready != '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pready", 64'(s_pready), 64'd0);
      end else begin
        e = exp_q.pop_front();
        exp_rd = '0;
        exp_rd[e.port*DW +: DW] = e.rdata;
        check("resp_pready", 64'(s_pready), 64'(N'(1) << e.port));
        check("resp_prdata", 64'(s_prdata), 64'(exp_rd));
        check("resp_pslverr", 64'(s_pslverr), 64'(N'(e.err) << e.port));
        check("resp_grant", 64'(grant), 64'(e.port));
      end
      resp_count++;
    end
  end

  task automatic push_exp(input int p, input logic [DW-1:0] rd, input logic err);
    resp_t e;
    e.port = p;
    e.rdata = rd;
    e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic request(input int p, input logic [AW-1:0] addr, input logic wr, input logic [DW-1:0] wd);
    s_paddr[p*AW +: AW] = addr;
    s_pwrite[p] = wr;
    s_pwdata[p*DW +: DW] = wd;
    s_psel[p] = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic run_until(input int target, input int budget, input logic auto_drop, output int acc_cycles);
    int n;
    acc_cycles = 0;
    n = 0;
    while (resp_count < target && n < budget) begin
      step();
      n++;
      if (m_psel && m_penable) acc_cycles++;
      if (auto_drop) s_psel = s_psel & ~s_pready;
    end
    if (resp_count < target) check("wait_for_response", 64'(resp_count), 64'(target));
  endtask

  task automatic reset_dut();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    int acc;
    int target;
    reset = 1'b1;
    s_paddr = '0; s_pwrite = '0; s_psel = '0; s_penable = '0; s_pwdata = '0;
    slave_never = 1'b0; slave_wait = 0; slave_key = '0;
    repeat (3) step();
    check("rst_psel", 64'(m_psel), 64'd0);
    check("rst_penable", 64'(m_penable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_grant", 64'(grant), 64'd0);
    check("rst_pready", 64'(s_pready), 64'd0);
    check("rst_prdata", 64'(s_prdata), 64'd0);
    reset = 1'b0;
    step();

    // Single read from requester 1, zero-wait slave.
    slave_key = 16'hBEEF ^ 16'h0040;
    request(1, 16'h0040, 1'b0, 16'h0000);
    push_exp(1, 16'hBEEF, 1'b0);
    step();
    check("t1_setup_psel", 64'(m_psel), 64'd1);
    check("t1_setup_penable", 64'(m_penable), 64'd0);
    check("t1_grant", 64'(grant), 64'd1);
    check("t1_paddr", 64'(m_paddr), 64'h0040);
    check("t1_busy", 64'(busy), 64'd1);
    step();
    check("t1_access_penable", 64'(m_penable), 64'd1);
    run_until(1, 10, 1'b1, acc);
    step();
    check("t1_idle_psel", 64'(m_psel), 64'd0);
    check("t1_idle_pready", 64'(s_pready), 64'd0);
    check("t1_prdata_hold", 64'(s_prdata), 64'hBEEF_0000);

    // All requesters pending continuously from reset.
    reset_dut();
    slave_key = 16'h5A5A;
    for (int p = 0; p < N; p++) request(p, AW'(16'h1000 + p * 16'h10), 1'b0, 16'h0000);
    for (int k = 0; k < 5; k++) push_exp(k % N, DW'(16'h1000 + (k % N) * 16'h10) ^ 16'h5A5A, 1'b0);
    run_until(resp_count + 5, 40, 1'b0, acc);
    s_psel = '0;
    step();
    step();
    check("t2_no_regrant", 64'(busy), 64'd0);

    // Write from requester 2 with three wait states; captured fields must hold.
    slave_wait = 3;
    slave_key = 16'h0F0F;
    request(2, 16'h0100, 1'b1, 16'h1234);
    push_exp(2, 16'h0100 ^ 16'h0F0F, 1'b0);
    target = resp_count + 1;
    acc = 0;
    for (int i = 0; i < 20 && resp_count < target; i++) begin
      step();
      s_psel = s_psel & ~s_pready;
      if (m_psel) begin
        s_paddr[2*AW +: AW] = 16'hDEAD;
        s_pwdata[2*DW +: DW] = 16'h0000;
        s_pwrite[2] = 1'b0;
        check("t3_paddr", 64'(m_paddr), 64'h0100);
        check("t3_pwdata", 64'(m_pwdata), 64'h1234);
        check("t3_pwrite", 64'(m_pwrite), 64'd1);
      end
      if (m_psel && m_penable) acc++;
    end
    if (resp_count < target) check("t3_wait", 64'(resp_count), 64'(target));
    check("t3_access_cycles", 64'(acc), 64'd4);
    step();

    // Watchdog abort on requester 3, then requester 1 is served.
    slave_wait = 0;
    slave_never = 1'b1;
    slave_key = 16'h3333;
    request(3, 16'h0300, 1'b0, 16'h0000);
    request(1, 16'h0110, 1'b1, 16'hCAFE);
    push_exp(3, 16'h0000, 1'b1);
    push_exp(1, 16'h0110 ^ 16'h3333, 1'b0);
    run_until(resp_count + 1, 30, 1'b1, acc);
    check("t4_timeout_cycles", 64'(acc), 64'd8);
    check("t4_psel_dropped", 64'(m_psel), 64'd0);
    slave_never = 1'b0;
    run_until(resp_count + 1, 20, 1'b1, acc);
    step();
    check("t4_requests_done", 64'(s_psel), 64'd0);

    // Reset in the middle of ACCESS drops the transfer.
    slave_never = 1'b1;
    request(0, 16'h0200, 1'b0, 16'h0000);
    for (int i = 0; i < 10 && !m_penable; i++) step();
    check("t5_reach_access", 64'(m_penable), 64'd1);
    reset = 1'b1;
    step();
    check("t5_rst_psel", 64'(m_psel), 64'd0);
    check("t5_rst_penable", 64'(m_penable), 64'd0);
    check("t5_rst_busy", 64'(busy), 64'd0);
    check("t5_rst_grant", 64'(grant), 64'd0);
    check("t5_rst_paddr", 64'(m_paddr), 64'd0);
    check("t5_rst_prdata", 64'(s_prdata), 64'd0);
    request(3, 16'h0330, 1'b0, 16'h0000);
    slave_never = 1'b0;
    push_exp(0, 16'h0200 ^ 16'h3333, 1'b0);
    push_exp(3, 16'h0330 ^ 16'h3333, 1'b0);
    reset = 1'b0;
    run_until(resp_count + 2, 30, 1'b1, acc);
    step();

    // Requester 1 withdraws during ACCESS; the transfer still completes once.
    slave_wait = 2;
    request(1, 16'h0444, 1'b0, 16'h0000);
    push_exp(1, 16'h0444 ^ 16'h3333, 1'b0);
    for (int i = 0; i < 10 && !m_penable; i++) step();
    check("t6_reach_access", 64'(m_penable), 64'd1);
    s_psel[1] = 1'b0;
    target = resp_count + 1;
    run_until(target, 20, 1'b1, acc);
    for (int i = 0; i < 6; i++) begin
      step();
      check("t6_idle_psel", 64'(m_psel), 64'd0);
      check("t6_idle_busy", 64'(busy), 64'd0);
    end
    check("t6_single_resp", 64'(resp_count), 64'(target));
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
